// File: rtl/barrett_reduce_ctrl.sv
// barrett_reduce_ctrl: sequenced Barrett reduction t = z mod q for a 128-bit z
// and 64-bit q, time-sharing one external 64x64 multiplier for both products.
// Optional macro BARRETT_CORR2_EN adds a second conditional-subtract state
// (CORR2) so the result is fully reduced; without it only CORR1 runs.
`timescale 1ns/1ps
module barrett_reduce_ctrl #(
    parameter int MUL_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] z,
    input  logic [63:0]  q,
    input  logic [63:0]  mu,
    input  logic [7:0]   k,
    output logic         mul_start,
    output logic [63:0]  mul_a,
    output logic [63:0]  mul_b,
    input  logic [127:0] mul_p,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  t,
    output logic         busy
);

    typedef enum logic [3:0] {
        IDLE,
        ISSUE1,
        WAIT1,
        ISSUE2,
        WAIT2,
        SUB,
        CORR1,
`ifdef BARRETT_CORR2_EN
        CORR2,
`endif
        DONE
    } state_t;

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

    state_t        state;
    state_t        state_n;
    logic [127:0]  z_r;
    logic [63:0]   q_r;
    logic [63:0]   mu_r;
    logic [7:0]    k_r;
    logic [63:0]   m3_r;
    logic [65:0]   p_r;
    logic [65:0]   r_r;
    logic [CW-1:0] cnt;
    logic          cnt_done;
    logic [65:0]   q_ext;

    assign cnt_done = (cnt == CNT_LAST);
    assign q_ext    = {2'b00, q_r};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = ISSUE1;
            ISSUE1:  state_n = WAIT1;
            WAIT1:   if (cnt_done) state_n = ISSUE2;
            ISSUE2:  state_n = WAIT2;
            WAIT2:   if (cnt_done) state_n = SUB;
            SUB:     state_n = CORR1;
`ifdef BARRETT_CORR2_EN
            CORR1:   state_n = CORR2;
            CORR2:   state_n = DONE;
`else
            CORR1:   state_n = DONE;
`endif
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture, multiplier wait counter and result arithmetic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_r  <= '0;
            q_r  <= '0;
            mu_r <= '0;
            k_r  <= '0;
            m3_r <= '0;
            p_r  <= '0;
            r_r  <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        z_r  <= z;
                        q_r  <= q;
                        mu_r <= mu;
                        k_r  <= k;
                    end
                end
                ISSUE1, ISSUE2: cnt <= '0;
                WAIT1: begin
                    cnt <= cnt + CW'(1);
                    if (cnt_done) m3_r <= 64'(mul_p >> k_r);
                end
                WAIT2: begin
                    cnt <= cnt + CW'(1);
                    // only the low 66 bits of z - p survive, so only they of p are kept
                    if (cnt_done) p_r <= mul_p[65:0];
                end
                SUB:   r_r <= z_r[65:0] - p_r;
                CORR1: if (r_r >= q_ext) r_r <= r_r - q_ext;
`ifdef BARRETT_CORR2_EN
                CORR2: if (r_r >= q_ext) r_r <= r_r - q_ext;
`endif
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the current state and held operand registers
    always_comb begin
        in_ready  = 1'b0;
        mul_start = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        out_valid = 1'b0;
        t         = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: in_ready = ~rst;
            ISSUE1, WAIT1: begin
                mul_start = (state == ISSUE1);
                mul_a     = 64'(z_r >> k_r);
                mul_b     = mu_r;
            end
            ISSUE2, WAIT2: begin
                mul_start = (state == ISSUE2);
                mul_a     = m3_r;
                mul_b     = q_r;
            end
            DONE: begin
                out_valid = 1'b1;
                t         = r_r[63:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_barrett_reduce_ctrl.sv
// Scoreboard bench for barrett_reduce_ctrl: a latency-1 instance gets directed
// and randomized traffic checked by a cycle-level monitor; a latency-4 instance
// gets one directed operation. Honors BARRETT_CORR2_EN like the design.
`timescale 1ns/1ps
module tb_barrett_reduce_ctrl;

    localparam int L1 = 1;
    localparam int L4 = 4;
`ifdef BARRETT_CORR2_EN
    localparam int NC = 2;
`else
    localparam int NC = 1;
`endif
    localparam int LAT1 = 4 + 2 * L1 + NC;
    localparam int LAT4 = 4 + 2 * L4 + NC;

    typedef struct {
        logic [63:0] t;
        logic [63:0] a1;
        logic [63:0] b1;
        logic [63:0] a2;
        logic [63:0] b2;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         in_valid = 1'b0, in_ready;
    logic [127:0] z = '0;
    logic [63:0]  q = '0, mu = '0;
    logic [7:0]   k = '0;
    logic         mul_start, out_valid, busy;
    logic         out_ready = 1'b1;
    logic [63:0]  mul_a, mul_b, t;
    logic [127:0] mul_p;

    logic         in_valid4 = 1'b0, in_ready4;
    logic [127:0] z4 = '0;
    logic [63:0]  q4 = '0, mu4 = '0;
    logic [7:0]   k4 = '0;
    logic         mul_start4, out_valid4, busy4;
    logic         out_ready4 = 1'b1;
    logic [63:0]  mul_a4, mul_b4, t4;
    logic [127:0] mul_p4;

    int nchecks = 0;
    int npass   = 0;
    int cyc     = 0;
    int last_acc = -1;
    int hs_cyc   = -1;
    logic [63:0] last_t = '0;
    bit rnd_ready = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    barrett_reduce_ctrl #(.MUL_LAT(L1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .z(z), .q(q), .mu(mu), .k(k),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .t(t), .busy(busy)
    );

    barrett_reduce_ctrl #(.MUL_LAT(L4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .z(z4), .q(q4), .mu(mu4), .k(k4),
        .mul_start(mul_start4), .mul_a(mul_a4), .mul_b(mul_b4), .mul_p(mul_p4),
        .out_valid(out_valid4), .out_ready(out_ready4), .t(t4), .busy(busy4)
    );

    // Multiplier models: product appears exactly L cycles after the start pulse,
    // random garbage at every other time so a mistimed capture is visible.
    logic [127:0] pipe1 [L1];
    logic [127:0] pipe4 [L4];
    always @(posedge clk) begin
        pipe1[0] <= mul_start ? 128'(mul_a) * 128'(mul_b)
                              : {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 1; i < L1; i++) pipe1[i] <= pipe1[i-1];
        pipe4[0] <= mul_start4 ? 128'(mul_a4) * 128'(mul_b4)
                               : {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 1; i < L4; i++) pipe4[i] <= pipe4[i-1];
    end
    assign mul_p  = pipe1[L1-1];
    assign mul_p4 = pipe4[L4-1];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        nchecks++;
        if (act === expv) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    endtask

    // Barrett reduction computed straight from the arithmetic definition
    function automatic exp_t model(input logic [127:0] zz, input logic [63:0] qq,
                                   input logic [63:0] mm, input logic [7:0] kk, input int acc);
        exp_t e;
        logic [127:0] zs, prod, ps, p, d;
        logic [65:0]  r;
        zs   = zz >> kk;
        e.a1 = zs[63:0];
        e.b1 = mm;
        prod = {64'd0, e.a1} * {64'd0, mm};
        ps   = prod >> kk;
        e.a2 = ps[63:0];
        e.b2 = qq;
        p    = {64'd0, e.a2} * {64'd0, qq};
        d    = zz - p;
        r    = d[65:0];
        for (int i = 0; i < NC; i++)
            if (r >= {2'b00, qq}) r = r - {2'b00, qq};
        e.t   = r[63:0];
        e.acc = acc;
        return e;
    endfunction

    // Accept side: push the expected response when a request is taken
    always @(posedge clk) begin
        if (rst) sb.delete();
        else if (in_valid && in_ready) begin
            sb.push_back(model(z, q, mu, k, cyc));
            last_acc = cyc;
        end
        cyc++;
    end

    // Monitor: compare every cycle against the oldest outstanding operation
    always @(negedge clk) begin
        exp_t e;
        int c;
        logic [63:0] ea, eb;
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_t", t, 0);
            chk("rst_mul_start", mul_start, 0);
            chk("rst_mul_a", mul_a, 0);
            chk("rst_mul_b", mul_b, 0);
            chk("rst_busy", busy, 0);
        end else if (sb.size() == 0) begin
            chk("idle_in_ready", in_ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_mul_start", mul_start, 0);
        end else begin
            e = sb[0];
            c = cyc - e.acc;
            chk("busy_in_ready", in_ready, 0);
            chk("busy_busy", busy, 1);
            chk("mul_start", mul_start, (c == 1 || c == 2 + L1));
            if (c >= 1 && c <= 1 + L1) begin
                ea = e.a1; eb = e.b1;
            end else if (c >= 2 + L1 && c <= 2 + 2 * L1) begin
                ea = e.a2; eb = e.b2;
            end else begin
                ea = '0; eb = '0;
            end
            chk("mul_a", mul_a, ea);
            chk("mul_b", mul_b, eb);
            chk("out_valid", out_valid, (c >= LAT1));
            if (out_valid) begin
                chk("t", t, e.t);
                if (out_ready) begin
                    last_t = t;
                    hs_cyc = cyc;
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Random backpressure while enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [127:0] zz, input logic [63:0] qq,
                        input logic [63:0] mm, input logic [7:0] kk);
        bit ok;
        ok = 1'b0;
        z = zz; q = qq; mu = mm; k = kk;
        in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", ok, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [7:0] kr;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed cases from the reduction examples
        send(128'd50, 64'd7, 64'd9, 8'd3);
        drain();
        chk("t_z50", last_t, 64'd1);
        send(128'd48, 64'd7, 64'd9, 8'd3);
        drain();
        chk("t_z48", last_t, 64'd6);
        send(128'd100, 64'd7, 64'd9362, 8'd8);
        drain();
        chk("t_z100", last_t, (NC == 2) ? 64'd86 : 64'd93);

        // Backpressure with a second request held during busy
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(128'd1000, 64'd13, 64'd19, 8'd4);
        z = 128'd50; q = 64'd7; mu = 64'd9; k = 8'd3;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_valid_timeout", ok, 1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(128'd50, 64'd7, 64'd9, 8'd3);
        chk("accept_after_hs", last_acc, hs_cyc + 1);
        drain();
        chk("t_after_bp", last_t, 64'd1);

        // Reset during WAIT2 aborts silently
        send(128'hdead_beef_0123_4567_89ab_cdef, 64'd1234567, 64'd987654, 8'd20);
        repeat (L1 + 2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        send(128'd50, 64'd7, 64'd9, 8'd3);
        drain();
        chk("t_after_rst", last_t, 64'd1);

        // Randomized traffic with random backpressure
        rnd_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            kr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255))
                                             : 8'($urandom_range(0, 127));
            send({$urandom(), $urandom(), $urandom(), $urandom()},
                 {$urandom(), $urandom()} | 64'd1,
                 {$urandom(), $urandom()}, kr);
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        // Latency-4 instance: single directed operation, cycle by cycle
        z4 = 128'd50; q4 = 64'd7; mu4 = 64'd9; k4 = 8'd3;
        in_valid4 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready4) begin
                ok = 1'b1;
                break;
            end
        end
        chk("l4_accept_timeout", ok, 1);
        @(posedge clk);
        #1 in_valid4 = 1'b0;
        for (int c = 1; c <= LAT4 + 2; c++) begin
            @(negedge clk);
            chk("l4_mul_start", mul_start4, (c == 1 || c == 2 + L4));
            if (mul_start4) begin
                chk("l4_mul_a", mul_a4, 64'd6);
                chk("l4_mul_b", mul_b4, (c == 1) ? 64'd9 : 64'd7);
            end
            chk("l4_out_valid", out_valid4, (c == LAT4));
            if (out_valid4) chk("l4_t", t4, 64'd1);
        end

        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
